// File: rtl/sprite_fetcher.sv
// Sprite fetcher: walks the active sprite list for one line, fetches tilemap and
// bitmap words over a single-outstanding handshake and writes doubled pixels to the line buffer.
`timescale 1ns/1ps

package sprite_fetcher_pkg;
    typedef struct packed {
        logic        x_flip;
        logic [5:0]  tile_count;
        logic [17:0] tilemap_addr;
    } active_tilemap_addr_t;

    typedef struct packed {
        logic [11:0] lb_addr;
        logic [17:0] tile_bitmap_addr;
    } active_bitmap_addr_t;
endpackage

module sprite_fetcher
    import sprite_fetcher_pkg::*;
#(
    parameter int unsigned LB_WIDTH = 1280
) (
    input  logic                 clk_draw,
    input  logic                 rst_draw,
    input  logic                 line,
    output logic [8:0]           sprite_index,
    input  logic                 valid,
    input  active_tilemap_addr_t tilemap_addr,
    input  active_bitmap_addr_t  bitmap_addr,
    output logic                 mem_req,
    output logic [17:0]          mem_addr,
    input  logic                 mem_ack,
    input  logic [15:0]          mem_rdata,
    output logic                 lb_we,
    output logic [11:0]          lb_addr,
    output logic [3:0]           lb_pixel,
    output logic                 done
);

    typedef enum logic [3:0] {
        IDLE, LOOKUP, CAPTURE, TMAP, BMAP0, BMAP1, DRAW, DONE, ABORT
    } state_t;

    state_t      state_q;
    logic [8:0]  idx_q;
    logic        req_q, we_q, done_q, flip_q;
    logic [17:0] addr_q, tm_q, tb_q;
    logic [11:0] x_q, lbx_q;
    logic [3:0]  pix_q, cnt_q;
    logic [5:0]  tc_q, t_q;
    logic [9:0]  tile_q;
    logic [15:0] w0_q, w1_q;

    logic [17:0] tile_addr_d, bmap_addr_d;
    logic [11:0] base_x_d, x_d;
    logic [3:0]  cnt_d, pix_d;
    logic [31:0] words_d;
    logic [2:0]  src_d;
    logic        we_d;

    // The first pixel is produced on the BMAP1 ack edge, so word1 comes straight from mem_rdata.
    always_comb begin
        tile_addr_d = flip_q ? (tm_q + 18'(tc_q) - 18'd1 - 18'(t_q)) : (tm_q + 18'(t_q));
        bmap_addr_d = tb_q + {7'd0, tile_q, 1'b0};
        base_x_d    = lbx_q + 12'({t_q, 4'd0});
        cnt_d       = (state_q == DRAW) ? cnt_q + 4'd1 : 4'd0;
        words_d     = (state_q == DRAW) ? {w1_q, w0_q} : {mem_rdata, w0_q};
        src_d       = cnt_d[3:1] ^ {3{flip_q}};
        pix_d       = words_d[{src_d, 2'b00} +: 4];
        x_d         = base_x_d + 12'(cnt_d);
        we_d        = (pix_d != '0) && (32'(x_d) < LB_WIDTH);
    end

    always_ff @(posedge clk_draw or posedge rst_draw) begin
        if (rst_draw) begin
            state_q <= IDLE;
            idx_q   <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            we_q    <= 1'b0;
            x_q     <= '0;
            pix_q   <= '0;
            done_q  <= 1'b0;
            flip_q  <= 1'b0;
            tc_q    <= '0;
            tm_q    <= '0;
            tb_q    <= '0;
            lbx_q   <= '0;
            t_q     <= '0;
            tile_q  <= '0;
            w0_q    <= '0;
            w1_q    <= '0;
            cnt_q   <= '0;
        end else begin
            we_q <= 1'b0;
            if (line && state_q != ABORT) begin
                done_q <= 1'b0;
                // A request accepted on this very edge needs no abort; its data is simply dropped.
                if (req_q && !mem_ack) begin
                    state_q <= ABORT;
                end else begin
                    req_q   <= 1'b0;
                    idx_q   <= '0;
                    state_q <= LOOKUP;
                end
            end else begin
                unique case (state_q)
                    IDLE, DONE: ;
                    LOOKUP: state_q <= CAPTURE;
                    CAPTURE: begin
                        if (!valid) begin
                            done_q  <= 1'b1;
                            state_q <= DONE;
                        end else if (tilemap_addr.tile_count == '0) begin
                            if (idx_q == 9'd511) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                idx_q   <= idx_q + 9'd1;
                                state_q <= LOOKUP;
                            end
                        end else begin
                            flip_q  <= tilemap_addr.x_flip;
                            tc_q    <= tilemap_addr.tile_count;
                            tm_q    <= tilemap_addr.tilemap_addr;
                            lbx_q   <= bitmap_addr.lb_addr;
                            tb_q    <= bitmap_addr.tile_bitmap_addr;
                            t_q     <= '0;
                            state_q <= TMAP;
                        end
                    end
                    TMAP: begin
                        if (!req_q) begin
                            req_q  <= 1'b1;
                            addr_q <= tile_addr_d;
                        end else if (mem_ack) begin
                            req_q   <= 1'b0;
                            tile_q  <= mem_rdata[9:0];
                            state_q <= BMAP0;
                        end
                    end
                    BMAP0: begin
                        if (!req_q) begin
                            req_q  <= 1'b1;
                            addr_q <= bmap_addr_d;
                        end else if (mem_ack) begin
                            req_q   <= 1'b0;
                            w0_q    <= mem_rdata;
                            state_q <= BMAP1;
                        end
                    end
                    BMAP1: begin
                        if (!req_q) begin
                            req_q  <= 1'b1;
                            addr_q <= bmap_addr_d + 18'd1;
                        end else if (mem_ack) begin
                            req_q   <= 1'b0;
                            w1_q    <= mem_rdata;
                            cnt_q   <= cnt_d;
                            we_q    <= we_d;
                            x_q     <= x_d;
                            pix_q   <= pix_d;
                            state_q <= DRAW;
                        end
                    end
                    DRAW: begin
                        if (cnt_q == 4'd15) begin
                            if (32'(t_q) + 32'd1 < 32'(tc_q)) begin
                                t_q     <= t_q + 6'd1;
                                state_q <= TMAP;
                            end else if (idx_q == 9'd511) begin
                                done_q  <= 1'b1;
                                state_q <= DONE;
                            end else begin
                                idx_q   <= idx_q + 9'd1;
                                state_q <= LOOKUP;
                            end
                        end else begin
                            cnt_q <= cnt_d;
                            we_q  <= we_d;
                            x_q   <= x_d;
                            pix_q <= pix_d;
                        end
                    end
                    ABORT: begin
                        if (mem_ack) begin
                            req_q   <= 1'b0;
                            idx_q   <= '0;
                            done_q  <= 1'b0;
                            state_q <= LOOKUP;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sprite_index = idx_q;
    assign mem_req      = req_q;
    assign mem_addr     = addr_q;
    assign lb_we        = we_q;
    assign lb_addr      = x_q;
    assign lb_pixel     = pix_q;
    assign done         = done_q;

endmodule

// File: tb/tb_sprite_fetcher.sv
// Bench for sprite_fetcher: sprite-list and memory responders, a list-level reference
// model of expected fetches and line-buffer writes, directed vectors and corner sequences.
`timescale 1ns/1ps

module tb_sprite_fetcher;
    import sprite_fetcher_pkg::*;

    localparam int unsigned LBW  = 1280;
    localparam int unsigned MASK = 32'h3FFFF;

    logic                 clk_draw;
    logic                 rst_draw;
    logic                 line;
    logic [8:0]           sprite_index;
    logic                 valid;
    active_tilemap_addr_t tilemap_addr;
    active_bitmap_addr_t  bitmap_addr;
    logic                 mem_req;
    logic [17:0]          mem_addr;
    logic                 mem_ack;
    logic [15:0]          mem_rdata;
    logic                 lb_we;
    logic [11:0]          lb_addr;
    logic [3:0]           lb_pixel;
    logic                 done;

    sprite_fetcher #(.LB_WIDTH(LBW)) dut (
        .clk_draw     (clk_draw),
        .rst_draw     (rst_draw),
        .line         (line),
        .sprite_index (sprite_index),
        .valid        (valid),
        .tilemap_addr (tilemap_addr),
        .bitmap_addr  (bitmap_addr),
        .mem_req      (mem_req),
        .mem_addr     (mem_addr),
        .mem_ack      (mem_ack),
        .mem_rdata    (mem_rdata),
        .lb_we        (lb_we),
        .lb_addr      (lb_addr),
        .lb_pixel     (lb_pixel),
        .done         (done)
    );

    initial clk_draw = 1'b0;
    always #5 clk_draw = ~clk_draw;

    int unsigned n_checks;
    int unsigned n_fail;

    logic        sp_flip [512];
    int unsigned sp_tc   [512];
    int unsigned sp_tm   [512];
    int unsigned sp_lb   [512];
    int unsigned sp_tb   [512];
    int unsigned sp_n;

    logic [15:0] mem_aa [int unsigned];
    int unsigned fixed_delay;
    bit          rand_delay;

    logic [17:0] got_req [$];
    logic [15:0] got_wr  [$];
    logic [17:0] exp_req [$];
    logic [15:0] exp_wr  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] memrd(input int unsigned a);
        logic [31:0] h;
        if (mem_aa.exists(a)) return mem_aa[a];
        h = a * 32'h9E3779B1;
        h = h ^ (h >> 15);
        return h[15:0];
    endfunction

    // Sprite-list and memory responder plus bus monitor, all evaluated at the falling edge.
    initial begin
        int unsigned w, dly, idx;
        logic        prev_req, prev_ack;
        logic [17:0] prev_addr;
        w = 0; dly = 0; prev_req = 1'b0; prev_ack = 1'b0; prev_addr = '0;
        valid = 1'b0; tilemap_addr = '0; bitmap_addr = '0; mem_ack = 1'b0; mem_rdata = '0;
        forever begin
            @(negedge clk_draw);
            idx = 32'(sprite_index);
            if (idx < sp_n) begin
                valid = 1'b1;
                tilemap_addr.x_flip       = sp_flip[idx];
                tilemap_addr.tile_count   = 6'(sp_tc[idx]);
                tilemap_addr.tilemap_addr = 18'(sp_tm[idx]);
                bitmap_addr.lb_addr          = 12'(sp_lb[idx]);
                bitmap_addr.tile_bitmap_addr = 18'(sp_tb[idx]);
            end else begin
                valid = 1'b0;
                tilemap_addr = 25'($urandom);
                bitmap_addr  = 30'($urandom);
            end
            if (prev_ack) check("req_low_after_ack", 32'(mem_req), 32'd0);
            if (mem_req && prev_req && !prev_ack) check("addr_stable", 32'(mem_addr), 32'(prev_addr));
            if (mem_req && !prev_req) begin
                got_req.push_back(mem_addr);
                w   = 0;
                dly = rand_delay ? $urandom_range(0, 3) : fixed_delay;
            end
            if (lb_we) got_wr.push_back({lb_addr, lb_pixel});
            if (mem_req && w >= dly) begin
                mem_ack   = 1'b1;
                mem_rdata = memrd(32'(mem_addr));
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 16'($urandom);
                if (mem_req) w++;
            end
            prev_req  = mem_req;
            prev_ack  = mem_ack;
            prev_addr = mem_addr;
        end
    end

    // Expected fetch addresses and visible writes for the whole sprite list.
    task automatic build_model();
        int unsigned ta, ti, a0, a1, src, x;
        logic [31:0] wd;
        logic [3:0]  p;
        exp_req.delete();
        exp_wr.delete();
        for (int unsigned s = 0; s < sp_n && s < 512; s++) begin
            for (int unsigned k = 0; k < sp_tc[s]; k++) begin
                ta = sp_flip[s] ? ((sp_tm[s] + sp_tc[s] - 1 - k) & MASK) : ((sp_tm[s] + k) & MASK);
                ti = 32'(memrd(ta)) & 32'h3FF;
                a0 = (sp_tb[s] + 2 * ti) & MASK;
                a1 = (a0 + 1) & MASK;
                exp_req.push_back(18'(ta));
                exp_req.push_back(18'(a0));
                exp_req.push_back(18'(a1));
                wd = {memrd(a1), memrd(a0)};
                for (int unsigned c = 0; c < 16; c++) begin
                    src = c / 2;
                    if (sp_flip[s]) src = 7 - src;
                    p = 4'((wd >> (4 * src)) & 32'hF);
                    x = (sp_lb[s] + 16 * k + c) % 4096;
                    if (p != 0 && x < LBW) exp_wr.push_back({12'(x), p});
                end
            end
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_nreq"}, got_req.size(), exp_req.size());
        for (int i = 0; i < exp_req.size() && i < got_req.size(); i++)
            check($sformatf("%s_req%0d", tag, i), 32'(got_req[i]), 32'(exp_req[i]));
        check({tag, "_nwr"}, got_wr.size(), exp_wr.size());
        for (int i = 0; i < exp_wr.size() && i < got_wr.size(); i++)
            check($sformatf("%s_wr%0d", tag, i), 32'(got_wr[i]), 32'(exp_wr[i]));
    endtask

    task automatic run_line(input int unsigned bound, output int unsigned cycles);
        @(negedge clk_draw);
        line = 1'b1;
        @(posedge clk_draw);
        #1 line = 1'b0;
        cycles = 0;
        while (cycles < bound) begin
            @(posedge clk_draw);
            #1 cycles++;
            if (done) break;
        end
        check("done_reached", 32'(done), 32'd1);
    endtask

    task automatic setup_single(input logic flip, input int unsigned tc, input int unsigned lb,
                                input int unsigned w0, input int unsigned w1);
        int unsigned a0;
        mem_aa.delete();
        sp_n = 1;
        sp_flip[0] = flip; sp_tc[0] = tc; sp_tm[0] = 32'h100; sp_lb[0] = lb; sp_tb[0] = 32'h2000;
        for (int unsigned k = 0; k < tc; k++) mem_aa[32'h100 + k] = 16'h0003;
        a0 = 32'h2000 + 2 * 3;
        mem_aa[a0]     = 16'(w0);
        mem_aa[a0 + 1] = 16'(w1);
    endtask

    typedef struct {
        logic        flip;
        int unsigned tc, lb, w0, w1, dly;
        int unsigned n_req, req0, req3, req_last, n_wr, first_wr, last_wr, cycles;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        int unsigned cyc, act;
        n_checks = 0; n_fail = 0;
        sp_n = 0; fixed_delay = 0; rand_delay = 1'b0;
        line = 1'b0;
        rst_draw = 1'b1;

        vecs[0] = '{flip:1'b0, tc:1, lb:10,   w0:'h4321, w1:'h0765, dly:0, n_req:3, req0:'h100, req3:0,
                    req_last:'h2007, n_wr:14, first_wr:10*16+1,   last_wr:23*16+7,    cycles:26};
        vecs[1] = '{flip:1'b1, tc:2, lb:10,   w0:'h4321, w1:'h0765, dly:0, n_req:6, req0:'h101, req3:'h100,
                    req_last:'h2007, n_wr:28, first_wr:12*16+7,   last_wr:41*16+1,    cycles:48};
        vecs[2] = '{flip:1'b0, tc:1, lb:1272, w0:'hFFFF, w1:'hFFFF, dly:0, n_req:3, req0:'h100, req3:0,
                    req_last:'h2007, n_wr:8,  first_wr:1272*16+15, last_wr:1279*16+15, cycles:26};
        vecs[3] = '{flip:1'b0, tc:1, lb:10,   w0:'h4321, w1:'h0765, dly:5, n_req:3, req0:'h100, req3:0,
                    req_last:'h2007, n_wr:14, first_wr:10*16+1,   last_wr:23*16+7,    cycles:41};
        vecs[4] = '{flip:1'b0, tc:1, lb:4090, w0:'h4321, w1:'h0765, dly:0, n_req:3, req0:'h100, req3:0,
                    req_last:'h2007, n_wr:8,  first_wr:0*16+4,    last_wr:7*16+7,     cycles:26};

        repeat (2) @(negedge clk_draw);
        check("rst_mem_req", 32'(mem_req), 0);
        check("rst_mem_addr", 32'(mem_addr), 0);
        check("rst_lb_we", 32'(lb_we), 0);
        check("rst_lb_addr", 32'(lb_addr), 0);
        check("rst_lb_pixel", 32'(lb_pixel), 0);
        check("rst_done", 32'(done), 0);
        check("rst_index", 32'(sprite_index), 0);
        rst_draw = 1'b0;
        repeat (3) @(negedge clk_draw);
        check("idle_no_req", 32'(mem_req), 0);

        for (int i = 0; i < 5; i++) begin
            setup_single(vecs[i].flip, vecs[i].tc, vecs[i].lb, vecs[i].w0, vecs[i].w1);
            fixed_delay = vecs[i].dly;
            rand_delay  = 1'b0;
            got_req.delete(); got_wr.delete();
            run_line(400, cyc);
            check($sformatf("v%0d_cycles", i), cyc, vecs[i].cycles);
            check($sformatf("v%0d_nreq", i), got_req.size(), vecs[i].n_req);
            if (got_req.size() > 0) begin
                check($sformatf("v%0d_req0", i), 32'(got_req[0]), vecs[i].req0);
                check($sformatf("v%0d_reqlast", i), 32'(got_req[got_req.size() - 1]), vecs[i].req_last);
            end
            if (vecs[i].n_req > 3 && got_req.size() > 3)
                check($sformatf("v%0d_req3", i), 32'(got_req[3]), vecs[i].req3);
            check($sformatf("v%0d_nwr", i), got_wr.size(), vecs[i].n_wr);
            if (got_wr.size() > 0) begin
                check($sformatf("v%0d_firstwr", i), 32'(got_wr[0]), vecs[i].first_wr);
                check($sformatf("v%0d_lastwr", i), 32'(got_wr[got_wr.size() - 1]), vecs[i].last_wr);
            end
            build_model();
            compare_model($sformatf("v%0d", i));
        end

        // Abort: restart the line while the first bitmap request is still pending.
        setup_single(1'b0, 1, 10, 'h4321, 'h0765);
        fixed_delay = 6; rand_delay = 1'b0;
        got_req.delete(); got_wr.delete();
        @(negedge clk_draw);
        line = 1'b1;
        @(posedge clk_draw);
        #1 line = 1'b0;
        act = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_draw);
            if (mem_req && mem_addr == 18'h2006) begin
                act = 1;
                break;
            end
        end
        check("abort_saw_bmap0", act, 1);
        line = 1'b1;
        @(posedge clk_draw);
        #1 line = 1'b0;
        check("abort_req_held", 32'(mem_req), 1);
        check("abort_addr_held", 32'(mem_addr), 32'h2006);
        cyc = 0;
        while (cyc < 400 && !done) begin
            @(posedge clk_draw);
            #1 cyc++;
        end
        check("abort_done", 32'(done), 1);
        check("abort_nreq", got_req.size(), 5);
        if (got_req.size() > 2) check("abort_restart_req", 32'(got_req[2]), 32'h100);
        for (int i = 0; i < 2 && i < got_req.size(); i++) void'(got_req.pop_front());
        build_model();
        compare_model("abort");

        // Reset pulsed in the middle of drawing.
        setup_single(1'b0, 1, 10, 'h4321, 'h0765);
        fixed_delay = 0;
        @(negedge clk_draw);
        line = 1'b1;
        @(posedge clk_draw);
        #1 line = 1'b0;
        act = 0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk_draw);
            if (lb_we) begin
                act = 1;
                break;
            end
        end
        check("rst_saw_draw", act, 1);
        rst_draw = 1'b1;
        #1;
        check("mid_rst_lb_we", 32'(lb_we), 0);
        check("mid_rst_lb_addr", 32'(lb_addr), 0);
        check("mid_rst_lb_pixel", 32'(lb_pixel), 0);
        check("mid_rst_mem_req", 32'(mem_req), 0);
        check("mid_rst_mem_addr", 32'(mem_addr), 0);
        check("mid_rst_index", 32'(sprite_index), 0);
        @(negedge clk_draw);
        rst_draw = 1'b0;
        act = 0;
        repeat (10) begin
            @(negedge clk_draw);
            if (mem_req || lb_we || done) act++;
        end
        check("post_rst_quiet", act, 0);
        got_req.delete(); got_wr.delete();
        run_line(400, cyc);
        build_model();
        compare_model("post_rst");

        // Randomized sprite lists against the reference model.
        rand_delay = 1'b1;
        for (int r = 0; r < 20; r++) begin
            mem_aa.delete();
            sp_n = $urandom_range(1, 5);
            for (int unsigned s = 0; s < sp_n; s++) begin
                sp_flip[s] = 1'($urandom);
                sp_tc[s]   = $urandom_range(0, 3);
                sp_tm[s]   = $urandom & MASK;
                sp_tb[s]   = $urandom & MASK;
                case ($urandom_range(0, 2))
                    0:       sp_lb[s] = $urandom_range(0, 1300);
                    1:       sp_lb[s] = $urandom_range(1260, 1290);
                    default: sp_lb[s] = $urandom_range(4080, 4095);
                endcase
            end
            got_req.delete(); got_wr.delete();
            build_model();
            run_line(3000, cyc);
            compare_model($sformatf("rnd%0d", r));
        end

        // Full 512-entry list of empty sprites ends at index 511 without wrapping.
        rand_delay = 1'b0;
        sp_n = 512;
        for (int unsigned s = 0; s < 512; s++) begin
            sp_flip[s] = 1'b0; sp_tc[s] = 0; sp_tm[s] = s; sp_lb[s] = 0; sp_tb[s] = 0;
        end
        got_req.delete(); got_wr.delete();
        run_line(3000, cyc);
        check("full_list_cycles", cyc, 1024);
        check("full_list_index", 32'(sprite_index), 511);
        check("full_list_nreq", got_req.size(), 0);
        repeat (5) @(negedge clk_draw);
        check("full_list_hold_done", 32'(done), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
